i2s_xmtr: RTL

//  I2S master transmitter. Generates SCK and WS from clk and serializes stereo samples onto SD.

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_xmtr_shift_reg.sv | 29 ++
 rtl/i2s_xmtr.sv | 139 +++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default channel width, frame length and the stereo pair type.
// The receiver path imports this package too, so keep it free of transmitter detail.
package i2s_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_FRAME_BITS = 2 * DEF_DATA_WIDTH;

   typedef struct packed {
      logic [DEF_DATA_WIDTH-1:0] left;
      logic [DEF_DATA_WIDTH-1:0] right;
   } stereo_pair_t;

   // One I2S frame carries both channels back to back.
   function automatic int frame_bits(input int data_width);
      return 2 * data_width;
   endfunction

endpackage

// File: rtl/i2s_xmtr_shift_reg.sv
// Parallel-load, MSB-first shift register holding the frame being serialized.
// serial_out is the registered MSB, so it only moves when load or shift fires.
module i2s_xmtr_shift_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] parallel_in,
   output logic             serial_out
);

   logic [WIDTH-1:0] sr;

   // Load has priority over shift; zero-fill from the LSB end as bits leave.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sr <= '0;
      end else if (load) begin
         sr <= parallel_in;
      end else if (shift) begin
         sr <= {sr[WIDTH-2:0], 1'b0};
      end
   end

   assign serial_out = sr[WIDTH-1];

endmodule

// File: rtl/i2s_xmtr.sv
// I2S master transmitter: generates SCK/WS from clk and shifts {left,right} pairs out on SD,
// MSB first with the standard one-SCK delay after each WS edge. A one-entry holding buffer
// behind a valid/ready handshake lets the next pair wait while the current frame is in flight.
module i2s_xmtr
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int SCK_DIV    = 4
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  enable,
   input  logic                  tx_valid,
   input  logic [DATA_WIDTH-1:0] tx_left,
   input  logic [DATA_WIDTH-1:0] tx_right,
   output logic                  tx_ready,
   output logic                  sck,
   output logic                  ws,
   output logic                  sd,
   output logic                  underrun
);

   localparam int FRAME_BITS = frame_bits(DATA_WIDTH);
   localparam int BCW        = $clog2(FRAME_BITS);
   localparam int DIVW       = $clog2(SCK_DIV) + 1;

   localparam logic [DIVW-1:0] DIV_LAST    = DIVW'(SCK_DIV - 1);
   localparam logic [BCW-1:0]  BC_LAST     = BCW'(FRAME_BITS - 1);
   localparam logic [BCW-1:0]  WS_HI_FIRST = BCW'(DATA_WIDTH - 1);
   localparam logic [BCW-1:0]  WS_HI_LAST  = BCW'(FRAME_BITS - 2);

   logic [DIVW-1:0]       div_cnt;
   logic [BCW-1:0]        bit_cnt;
   logic [BCW-1:0]        k;
   logic                  tc;
   logic                  fall_evt;
   logic                  frame_start;
   logic                  accept;
   logic                  bypass;
   logic                  buf_full;
   logic [DATA_WIDTH-1:0] buf_left;
   logic [DATA_WIDTH-1:0] buf_right;
   logic [FRAME_BITS-1:0] load_val;
   logic                  load_empty;
   logic                  sr_load;
   logic [FRAME_BITS-1:0] sr_in;

   // The SCK falling edge is the only moment SD, WS and the frame position advance.
   assign tc          = enable && (div_cnt == DIV_LAST);
   assign fall_evt    = tc && sck;
   assign k           = (bit_cnt == BC_LAST) ? '0 : bit_cnt + 1'b1;
   assign frame_start = fall_evt && (k == '0);
   assign accept      = tx_valid && !buf_full;
   assign bypass      = frame_start && !buf_full && tx_valid;
   assign tx_ready    = !buf_full;

   // Divider and SCK: toggle at terminal count, everything parked at zero while disabled.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         div_cnt <= '0;
         sck     <= 1'b0;
      end else if (!enable) begin
         div_cnt <= '0;
         sck     <= 1'b0;
      end else if (tc) begin
         div_cnt <= '0;
         sck     <= ~sck;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Frame position and WS; WS flips on the last bit of each word so it leads the next MSB.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         bit_cnt <= BC_LAST;
         ws      <= 1'b0;
      end else if (!enable) begin
         bit_cnt <= BC_LAST;
         ws      <= 1'b0;
      end else if (fall_evt) begin
         bit_cnt <= k;
         ws      <= (k >= WS_HI_FIRST) && (k <= WS_HI_LAST);
      end
   end

   // Choose what the next frame carries: buffered pair, then a same-cycle offer, then silence.
   always_comb begin
      load_val   = '0;
      load_empty = 1'b0;
      if (buf_full) begin
         load_val = {buf_left, buf_right};
      end else if (tx_valid) begin
         load_val = {tx_left, tx_right};
      end else begin
         load_empty = 1'b1;
      end
   end

   // Holding buffer: drained by a frame load, filled by any accept that is not a bypass.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         buf_full  <= 1'b0;
         buf_left  <= '0;
         buf_right <= '0;
      end else if (frame_start && buf_full) begin
         buf_full <= 1'b0;
      end else if (accept && !bypass) begin
         buf_full  <= 1'b1;
         buf_left  <= tx_left;
         buf_right <= tx_right;
      end
   end

   // Underrun flags a frame that had to start from zeros, aligned with that frame's first bit.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         underrun <= 1'b0;
      end else begin
         underrun <= frame_start && load_empty;
      end
   end

   // Disabling reloads zeros every cycle, which both clears SD and discards the frame in flight.
   assign sr_load = frame_start || !enable;
   assign sr_in   = enable ? load_val : '0;

   i2s_xmtr_shift_reg #(
      .WIDTH(FRAME_BITS)
   ) u_shift_reg (
      .clk        (clk),
      .n_rst      (n_rst),
      .load       (sr_load),
      .shift      (fall_evt),
      .parallel_in(sr_in),
      .serial_out (sd)
   );

endmodule
